// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default FIFO depth and TX-FIFO launch FSM states.
package uart_pkg;
  localparam int UART_BYTE_W             = 8;
  localparam int UART_FIFO_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    WAIT_DONE = 2'd2
  } uart_tx_fifo_state_t;
endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// byte_fifo: circular byte buffer with registered occupancy count; shared by the TX and RX paths.
module byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_FIFO_DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_en_i,
  input  logic [UART_BYTE_W-1:0] wr_data_i,
  input  logic                   rd_en_i,
  output logic [UART_BYTE_W-1:0] rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       count_o
);

  logic [UART_BYTE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});
  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign w_push  = wr_en_i && !w_full;
  assign w_pop   = rd_en_i && !w_empty;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  assign rd_data_o = r_mem[r_rd_ptr];
  assign full_o    = w_full;
  assign empty_o   = w_empty;
  assign count_o   = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers bytes and launches them one frame at a time into the UART transmitter.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_FIFO_DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [UART_BYTE_W-1:0] wr_data_i,
  input  logic                   wr_en_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       count_o,
  output logic [UART_BYTE_W-1:0] uart_tx_data_o,
  output logic                   uart_tx_trigger_o,
  input  logic                   uart_tx_complete_i
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                   overflow_o,
  input  logic                   overflow_clr_i
`endif
);

  uart_tx_fifo_state_t    r_state;
  logic [UART_BYTE_W-1:0] r_tx_data;
  logic                   r_trigger;
  logic [UART_BYTE_W-1:0] w_rd_data;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (wr_en_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (w_pop),
    .rd_data_o (w_rd_data),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .count_o   (count_o)
  );

  // Launch only when the transmitter reports idle, so a finished frame never retriggers.
  assign w_pop = (r_state == IDLE) && !w_empty && uart_tx_complete_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_tx_data <= {UART_BYTE_W{1'b0}};
      r_trigger <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_rd_data;
            r_trigger <= 1'b1;
            r_state   <= ARM;
          end
        end
        ARM: begin
          if (!uart_tx_complete_i) begin
            r_trigger <= 1'b0;
            r_state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (uart_tx_complete_i) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_trigger <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;
  logic w_drop;

  assign w_drop = wr_en_i && w_full;

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr_i) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow_o = r_overflow;
`endif

  assign full_o            = w_full;
  assign empty_o           = w_empty;
  assign uart_tx_data_o    = r_tx_data;
  assign uart_tx_trigger_o = r_trigger;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a behavioural 8N1 transmitter/receiver model.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       tx_hold = 1'b0;
  logic       full, empty, trig, tx_cmp;
  logic [4:0] count;
  logic [7:0] tx_data;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf;
  logic       ovf_clr = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // transmitter model state
  logic       m_busy = 1'b0;
  logic       m_cmp = 1'b1;
  logic [9:0] m_sh = 10'h3FF;
  logic [9:0] m_rx = 10'h000;
  logic [9:0] last_frame = 10'h000;
  logic [7:0] m_data = 8'h00;
  logic       line;
  int         m_bit = 0;
  int         m_clk = 0;
  int         stab_err = 0;
  bit         stab_en = 1'b1;
  logic [7:0] rxq[$];
  logic       trig_d = 1'b0;
  int         trig_cnt = 0;

  always #5 clk = ~clk;

  assign tx_cmp = m_cmp & ~tx_hold;
  assign line   = m_busy ? m_sh[0] : 1'b1;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .wr_data_i          (wr_data),
    .wr_en_i            (wr_en),
    .full_o             (full),
    .empty_o            (empty),
    .count_o            (count),
    .uart_tx_data_o     (tx_data),
    .uart_tx_trigger_o  (trig),
    .uart_tx_complete_i (tx_cmp)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .overflow_o         (ovf),
    .overflow_clr_i     (ovf_clr)
`endif
  );

  always @(posedge clk) begin
    if (!m_busy) begin
      if (trig && !tx_hold) begin
        m_busy <= 1'b1;
        m_cmp  <= 1'b0;
        m_sh   <= {1'b1, tx_data, 1'b0};
        m_data <= tx_data;
        m_bit  <= 0;
        m_clk  <= 0;
      end
    end else begin
      if (stab_en && tx_data !== m_data) stab_err <= stab_err + 1;
      if (m_clk == CPB / 2) m_rx <= {line, m_rx[9:1]};
      if (m_clk == CPB - 1) begin
        m_clk <= 0;
        m_sh  <= {1'b1, m_sh[9:1]};
        if (m_bit == 9) begin
          m_busy     <= 1'b0;
          m_cmp      <= 1'b1;
          last_frame <= m_rx;
          rxq.push_back(m_rx[8:1]);
        end else begin
          m_bit <= m_bit + 1;
        end
      end else begin
        m_clk <= m_clk + 1;
      end
    end
  end

  always @(posedge clk) begin
    trig_d <= trig;
    if (trig && !trig_d) trig_cnt <= trig_cnt + 1;
  end

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while ((rxq.size() < n || m_busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rxq.size() < n) begin
      failures++;
      $display("FAIL rx_timeout got=%0d want=%0d", rxq.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
    end
    checks++;
    if (tx_data !== 8'h00 || trig !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs data=%h trig=%b want 00/0", tx_data, trig);
    end
`ifdef UART_TX_FIFO_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b want=0", ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t0;
    rxq.delete();
    t0 = trig_cnt;
    push(8'hA5);
    checks++;
    if (count !== 5'd1 || empty !== 1'b0 || trig !== 1'b0) begin
      failures++;
      $display("FAIL single_c1 count=%0d empty=%b trig=%b want 1/0/0", count, empty, trig);
    end
    @(negedge clk);
    checks++;
    if (trig !== 1'b1 || tx_data !== 8'hA5 || empty !== 1'b1) begin
      failures++;
      $display("FAIL single_launch trig=%b data=%h empty=%b want 1/a5/1", trig, tx_data, empty);
    end
    @(negedge clk);
    checks++;
    if (trig !== 1'b1) begin
      failures++;
      $display("FAIL single_trig_w2 got=%b want=1", trig);
    end
    @(negedge clk);
    checks++;
    if (trig !== 1'b0) begin
      failures++;
      $display("FAIL single_trig_drop got=%b want=0", trig);
    end
    wait_rx(1, 500);
    checks++;
    if (last_frame !== 10'b1101001010 || rxq.size() != 1) begin
      failures++;
      $display("FAIL single_frame got=%b n=%0d want=1101001010 n=1", last_frame, rxq.size());
    end
    checks++;
    if (trig_cnt - t0 != 1 || empty !== 1'b1 || stab_err != 0) begin
      failures++;
      $display("FAIL single_after trigs=%0d empty=%b stab=%0d want 1/1/0", trig_cnt - t0, empty, stab_err);
    end
  endtask

  task automatic test_burst();
    int t0;
    rxq.delete();
    t0 = trig_cnt;
    tx_hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h30 + 8'(i);
      wr_en   = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || trig !== 1'b0) begin
      failures++;
      $display("FAIL burst_full count=%0d full=%b trig=%b want 16/1/0", count, full, trig);
    end
    tx_hold = 1'b0;
    wait_rx(16, 3000);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rxq[i] !== 8'h30 + 8'(i)) begin
        failures++;
        $display("FAIL burst_byte%0d got=%h want=%h", i, rxq[i], 8'h30 + 8'(i));
      end
    end
    checks++;
    if (trig_cnt - t0 != 16 || empty !== 1'b1) begin
      failures++;
      $display("FAIL burst_trigs got=%0d empty=%b want 16/1", trig_cnt - t0, empty);
    end
  endtask

  task automatic test_overflow();
    rxq.delete();
    tx_hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    push(8'hFF);
    checks++;
    if (count !== 5'd16 || full !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drop count=%0d full=%b want 16/1", count, full);
    end
`ifdef UART_TX_FIFO_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b want=1", ovf);
    end
    ovf_clr = 1'b1;
    push(8'hFF);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_wins got=%b want=1", ovf);
    end
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b want=0", ovf);
    end
`endif
    tx_hold = 1'b0;
    push(8'hEE);
    checks++;
    if (count !== 5'd15 || trig !== 1'b1) begin
      failures++;
      $display("FAIL ovf_pop_drop count=%0d trig=%b want 15/1", count, trig);
    end
`ifdef UART_TX_FIFO_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_pop_set got=%b want=1", ovf);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
`endif
    wait_rx(16, 3000);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rxq[i] !== 8'h40 + 8'(i)) begin
        failures++;
        $display("FAIL ovf_byte%0d got=%h want=%h", i, rxq[i], 8'h40 + 8'(i));
      end
    end
  endtask

  task automatic test_push_pop();
    rxq.delete();
    tx_hold = 1'b1;
    push(8'h60);
    push(8'h61);
    push(8'h62);
    checks++;
    if (count !== 5'd3) begin
      failures++;
      $display("FAIL pp_pre count=%0d want=3", count);
    end
    tx_hold = 1'b0;
    push(8'h63);
    checks++;
    if (count !== 5'd3 || trig !== 1'b1) begin
      failures++;
      $display("FAIL pp_same count=%0d trig=%b want 3/1", count, trig);
    end
    wait_rx(4, 1000);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rxq[i] !== 8'h60 + 8'(i)) begin
        failures++;
        $display("FAIL pp_byte%0d got=%h want=%h", i, rxq[i], 8'h60 + 8'(i));
      end
    end
  endtask

  task automatic test_wrap();
    int t0;
    int t;
    rxq.delete();
    t0 = trig_cnt;
    for (int i = 0; i < 40; i++) begin
      t = 0;
      while (full && t < 500) begin
        @(negedge clk);
        t++;
      end
      push(8'(i));
    end
    wait_rx(40, 5000);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (rxq[i] !== 8'(i)) begin
        failures++;
        $display("FAIL wrap_byte%0d got=%h want=%h", i, rxq[i], 8'(i));
      end
    end
    checks++;
    if (trig_cnt - t0 != 40 || stab_err != 0) begin
      failures++;
      $display("FAIL wrap_trigs got=%0d stab=%0d want 40/0", trig_cnt - t0, stab_err);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int viol;
    rxq.delete();
    stab_en = 1'b0;
    push(8'h55);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    t = 0;
    while (!(m_busy && m_bit == 4) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (count !== 5'd4) begin
      failures++;
      $display("FAIL rm_queued count=%0d want=4", count);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || trig !== 1'b0) begin
      failures++;
      $display("FAIL rm_after count=%0d empty=%b trig=%b want 0/1/0", count, empty, trig);
    end
    push(8'h77);
    viol = 0;
    t = 0;
    while (m_busy && t < 200) begin
      if (trig !== 1'b0) viol++;
      @(negedge clk);
      t++;
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL rm_trig_busy got=%0d high cycles want=0", viol);
    end
    wait_rx(2, 1000);
    repeat (100) @(negedge clk);
    checks++;
    if (rxq.size() != 2 || rxq[0] !== 8'h55 || rxq[1] !== 8'h77) begin
      failures++;
      $display("FAIL rm_seq n=%0d b0=%h b1=%h want 2/55/77", rxq.size(), rxq[0], rxq[1]);
    end
    stab_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_push_pop();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch sequencer that sits directly upstream of the UART transmitter. It accepts bytes from application logic at up to one per clock and stores them in a DEPTH-entry FIFO. It drives the transmitter's data/trigger inputs one byte at a time, holding data stable for the whole frame, and waits on the transmitter's idle flag between bytes. Its purpose is to decouple bursty producers, such as a debug dumper or an echo path, from the fixed UART bit rate.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256.
- CNT_W, $clog2(DEPTH)+1, width of count_o (derived; not overridden).

- clk_i  in  1  system clock (27 MHz); all logic on posedge.
- rst_n_i  in  1  reset, synchronous, active-low.
- wr_data_i  in  8  byte to enqueue.
- wr_en_i  in  1  enqueue strobe; one byte per cycle while high.
- full_o  out  1  FIFO holds DEPTH bytes.
- empty_o  out  1  FIFO holds 0 bytes (a byte in flight on the UART is not counted).
- count_o  out  CNT_W  bytes currently stored.
- uart_tx_data_o  out  8  to transmitter tx_data_i; held constant for the whole frame.
- uart_tx_trigger_o  out  1  to transmitter tx_trigger_i.
- uart_tx_complete_i  in  1  from transmitter tx_complete_o; 1 = transmitter idle.
- overflow_o  out  1  sticky dropped-write flag (only with UART_TX_FIFO_OVF_EN).
- overflow_clr_i  in  1  clears overflow_o (only with UART_TX_FIFO_OVF_EN).

## Operation
- The FIFO uses a circular buffer with read and write pointers of $clog2(DEPTH) bits. Pointers wrap naturally.
- count_o is a registered counter:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged, and both operations take effect.
- full_o and empty_o decode from the registered count_o.
- A write with full_o=1 is dropped, even if a pop occurs in the same cycle. It does not alter the pointers or the count.
- FSM states: IDLE, ARM, WAIT_DONE.
  - IDLE: if empty_o=0 and uart_tx_complete_i=1:
    - latch mem[rd_ptr] into uart_tx_data_o.
    - advance rd_ptr (pop).
    - go to ARM.
  - ARM: assert uart_tx_trigger_o. When uart_tx_complete_i=0 is seen, deassert the trigger and go to WAIT_DONE.
  - WAIT_DONE: uart_tx_data_o is held. When uart_tx_complete_i=1, go to IDLE.
- uart_tx_data_o changes only on the IDLE→ARM transition. The transmitter samples data continuously, so the data must not change at any other time.
- The trigger is never asserted while uart_tx_complete_i=1 in IDLE. This prevents a second launch after the frame ends.

## Timing
- Reset values:
  - full_o=0, empty_o=1, count_o=0.
  - uart_tx_data_o=8'h00, uart_tx_trigger_o=0, overflow_o=0.
  - FSM in IDLE, pointers at 0.
- Write-to-visible: count_o and empty_o update on the edge after wr_en_i is sampled.
- Launch latency: if the FIFO was empty, uart_tx_trigger_o rises 2 cycles after the wr_en_i edge:
  - cycle 1: count update.
  - cycle 2: IDLE→ARM.
- Trigger width: uart_tx_trigger_o is high from ARM entry until the cycle uart_tx_complete_i is observed low. With the team transmitter this is 2 cycles.
- Back-to-back frames: IDLE is occupied for 1 cycle between frames. The inter-frame gap is 1 clock plus the transmitter's stop bit.
- Reset mid-frame: the FSM returns to IDLE and the queued bytes are discarded. The in-flight UART frame is not aborted by this block. IDLE blocks relaunch until uart_tx_complete_i=1.

## Configuration
- UART_TX_FIFO_OVF_EN defined:
  - overflow_o sets on any dropped write and stays set.
  - overflow_clr_i=1 clears it on the next edge.
  - If set and clear coincide, set wins.
- UART_TX_FIFO_OVF_EN undefined:
  - overflow_o and overflow_clr_i ports are absent.
  - Dropped writes are silent.

## Structure
- The shared package uart_pkg holds:
  - UART_BYTE_W = 8.
  - the FSM state typedef uart_tx_fifo_state_t (IDLE, ARM, WAIT_DONE).
  - the default depth constant UART_FIFO_DEPTH_DEFAULT = 16.
- One sub-module: byte_fifo, containing the storage, pointers, count, full and empty logic. It is reused later for the RX-side buffer.
- The uart_tx_fifo top holds only the FSM and the output registers.

## Test plan
- Single byte: write 8'hA5 after reset → trigger is high 2 cycles later. uart_tx_data_o=8'hA5 for the whole frame. The serial line shows start, 10100101 LSB-first, stop. empty_o=1 afterwards.
- Burst: write 8'h30..8'h3F on 16 consecutive cycles with DEPTH=16 → full_o=1, count_o=16. All 16 bytes are transmitted in order, with exactly one trigger per byte.
- Overflow: fill with 16 bytes, then write 8'hFF with no pop → the byte is dropped and count_o stays 16. With UART_TX_FIFO_OVF_EN, overflow_o=1 until overflow_clr_i is pulsed.
- Simultaneous push and pop: count_o=3 and the FSM is popping in IDLE while wr_en_i=1 → count_o stays 3 and the new byte is sent last.
- Wrap-around: push and send 40 bytes (0x00..0x27) through DEPTH=16 → the received sequence is exact across two pointer wraps.
- Reset mid-frame: assert rst_n_i=0 for 1 cycle during bit 3 of 8'h55 with 4 bytes queued → count_o=0 and trigger stays low. The current frame completes unmodified, and a new write is sent only after uart_tx_complete_i=1.
